seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter N_BITS, default 15, sets the divisor, quotient and remainder width; the dividend is 2*N_BITS wide; legal range N_BITS >= 2.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  the operand pair on n and d is valid.
REQ-005 in_ready  output  1  the block accepts operands this cycle.
REQ-006 n  input  2*N_BITS  dividend, unsigned.
REQ-007 d  input  N_BITS  divisor, unsigned.
REQ-008 out_valid  output  1  q, r and the flags hold a valid result.
REQ-009 out_ready  input  1  the consumer takes the result this cycle.
REQ-010 q  output  N_BITS  quotient, unsigned.
REQ-011 r  output  N_BITS  remainder, unsigned.
REQ-012 div_by_zero  output  1  the accepted divisor was 0.
REQ-013 overflow  output  1  d is nonzero and the quotient does not fit in N_BITS bits (n[2N-1:N] >= d).

Function
REQ-014 The block is the inverse of the N_BITS x N_BITS -> 2*N_BITS multiplier: for a legal operation, n = q*d + r with r < d.
REQ-015 FSM states are IDLE, CALC and DONE.
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
REQ-016 Accept: in IDLE with in_valid=1 at edge T, capture n and d.
  - Error case (d==0 or overflow): go to DONE; out_valid=1 in cycle T+1.
  - Otherwise: go to CALC with the iteration counter set to N_BITS.
REQ-017 CALC performs one restoring step per cycle.
  - Partial remainder is N_BITS+1 bits, initialised to n[2N-1:N].
  - Each step: shift left, taking in the next dividend bit, MSB first.
  - If the shifted value >= d: subtract d and shift in quotient bit 1; else shift in 0.
REQ-018 CALC lasts exactly N_BITS cycles, then goes to DONE; out_valid=1 in cycle T+N_BITS+1.
REQ-019 Error results:
  - d==0: q=0, r=0, div_by_zero=1, overflow=0.
  - Overflow: q=0, r=0, div_by_zero=0, overflow=1.
  - A legal result has both flags at 0.
REQ-020 In DONE, q, r and the flags stay stable until out_valid && out_ready; on that edge the FSM returns to IDLE.
REQ-021 No input is accepted in the same cycle the result is consumed; the minimum issue interval is N_BITS+2 cycles (legal) or 2 cycles (error).
REQ-022 in_valid, n and d are ignored outside IDLE; out_ready is ignored outside DONE.
REQ-023 Boundaries:
  - d=1 yields q=n[N-1:0], r=0 when n[2N-1:N]==0.
  - n=0 yields q=0, r=0.
  - Maximum legal case: n=(2^N-1)^2, d=2^N-1 yields q=2^N-1, r=0.

Reset
REQ-024 When rst=1 at an edge: state becomes IDLE, counter 0, and q, r, div_by_zero, overflow become 0.
  - Cycle after reset: in_ready=1, out_valid=0.
REQ-025 Reset during CALC or DONE discards the operation; no result is emitted for it.

Structure
REQ-026 State encodings and the counter width (clog2(N_BITS+1)) are defined as localparams in a shared arithmetic definitions include, reused by later iterative arithmetic blocks.
REQ-027 One combinational sub-module, restoring_div_step, SHALL implement one step (partial remainder, divisor -> next remainder, quotient bit); seq_div instantiates it once.

Verification (N_BITS=15; T = accept edge)
REQ-028 n=100, d=7 -> out_valid at T+16; q=14, r=2; both flags 0.
REQ-029 n=1073676289, d=32767 -> q=32767, r=0, no flags.
  - n=163840, d=5 -> overflow=1, q=0, r=0, out_valid at T+1.
REQ-030 d=0, n=1234 -> div_by_zero=1, overflow=0, q=0, r=0, out_valid at T+1.
REQ-031 n=100, d=7, out_ready held 0 for 3 cycles after out_valid:
  - Outputs are stable throughout.
  - in_ready=0 until the cycle after the handshake.
  - in_valid pulses are ignored during the hold.
REQ-032 rst=1 at the 5th CALC cycle -> next cycle in_ready=1, out_valid=0; a new n=50, d=3 then yields q=16, r=2.
REQ-033 Round trip: 1000 random legal (a, b, r<b) -> n = karatsuba_mul(a, b) + r, d = b -> q=a, r=r.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared definitions for the iterative arithmetic blocks: FSM encodings and counter sizing.
package seq_div_pkg;

    localparam int unsigned DEF_N_BITS = 15;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_CALC = 2'd1;
    localparam logic [1:0] ENC_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ENC_IDLE,
        CALC = ENC_CALC,
        DONE = ENC_DONE
    } state_e;

    // Iteration counter must hold the value n_bits itself.
    function automatic int unsigned cnt_width(input int unsigned n_bits);
        return $clog2(n_bits + 1);
    endfunction

endpackage

// File: rtl/seq_div_if.sv
// Operand/result handshake bundle for the sequential divider.
interface seq_div_if #(
    parameter int unsigned N_BITS = 15
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [2*N_BITS-1:0]   n;
    logic [N_BITS-1:0]     d;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_BITS-1:0]     q;
    logic [N_BITS-1:0]     r;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output in_valid, n, d, out_ready,
        input  in_ready, out_valid, q, r, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, n, d, out_ready,
        output in_ready, out_valid, q, r, div_by_zero, overflow
    );

endinterface

// File: rtl/restoring_div_step.sv
// One restoring-division step: shift in a dividend bit, conditionally subtract the divisor.
module restoring_div_step #(
    parameter int unsigned N_BITS = 15
) (
    input  logic [N_BITS:0]   rem_i,
    input  logic              bit_i,
    input  logic [N_BITS-1:0] dvs_i,
    output logic [N_BITS:0]   rem_o,
    output logic              qbit_o
);

    logic [N_BITS+1:0] shifted;

    always_comb begin
        shifted = {rem_i, bit_i};
        qbit_o  = 1'b0;
        rem_o   = (N_BITS+1)'(shifted);
        if (shifted >= {2'b00, dvs_i}) begin
            qbit_o = 1'b1;
            rem_o  = (N_BITS+1)'(shifted - {2'b00, dvs_i});
        end
    end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per cycle.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int unsigned N_BITS = DEF_N_BITS
) (
    input  logic      clk,
    input  logic      rst,
    seq_div_if.slave  bus
);

    localparam int unsigned CNT_W = cnt_width(N_BITS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_BITS:0]     rem_q, rem_d;
    logic [N_BITS-1:0]   dvd_q, dvd_d;
    logic [N_BITS-1:0]   dvs_q, dvs_d;
    logic [N_BITS-1:0]   quo_q, quo_d;
    logic [N_BITS-1:0]   q_q, q_d;
    logic [N_BITS-1:0]   r_q, r_d;
    logic                dbz_q, dbz_d;
    logic                ovf_q, ovf_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [N_BITS-1:0]   n_hi, n_lo;
    logic [N_BITS:0]     step_rem;
    logic                step_qbit;

    assign n_hi = bus.n[2*N_BITS-1:N_BITS];
    assign n_lo = bus.n[N_BITS-1:0];

    restoring_div_step #(
        .N_BITS (N_BITS)
    ) u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[N_BITS-1]),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        q_d         = q_q;
        r_d         = r_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dvs_d = bus.d;
                    if (bus.d == '0) begin
                        q_d     = '0;
                        r_d     = '0;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else if (n_hi >= bus.d) begin
                        q_d     = '0;
                        r_d     = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = {1'b0, n_hi};
                        dvd_d   = n_lo;
                        quo_d   = '0;
                        cnt_d   = CNT_W'(N_BITS);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[N_BITS-2:0], 1'b0};
                quo_d = {quo_q[N_BITS-2:0], step_qbit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    q_d     = {quo_q[N_BITS-2:0], step_qbit};
                    r_d     = step_rem[N_BITS-1:0];
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.q           = q_q;
    assign bus.r           = r_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed and round-trip checks of seq_div at N_BITS=15.
module tb_seq_div;

    localparam int unsigned NB = 15;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    seq_div_if #(.N_BITS(NB)) bus ();

    seq_div #(.N_BITS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // 8-bit split Karatsuba product of two 15-bit operands
    function automatic longint unsigned karatsuba_mul(input longint unsigned a, input longint unsigned b);
        longint unsigned a0, a1, b0, b1, z0, z1, z2;
        a0 = a & 64'hFF;
        a1 = a >> 8;
        b0 = b & 64'hFF;
        b1 = b >> 8;
        z0 = a0 * b0;
        z2 = a1 * b1;
        z1 = (a0 + a1) * (b0 + b1) - z2 - z0;
        return (z2 << 16) + (z1 << 8) + z0;
    endfunction

    // Issue one operation, measure latency, optionally stall the result, then consume it.
    task automatic run_op(input string tag, input logic [2*NB-1:0] n_v, input logic [NB-1:0] d_v,
                          input int hold, input logic [NB-1:0] eq, input logic [NB-1:0] er,
                          input logic edbz, input logic eovf, input int elat);
        int w;
        int lat;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, ".ready"}, 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b1;
        bus.n        = n_v;
        bus.d        = d_v;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 100);
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".q"},   64'(bus.q), 64'(eq));
        check({tag, ".r"},   64'(bus.r), 64'(er));
        check({tag, ".dbz"}, 64'(bus.div_by_zero), 64'(edbz));
        check({tag, ".ovf"}, 64'(bus.overflow), 64'(eovf));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.n        = 30'(h + 3);
            bus.d        = 15'd1;
            @(negedge clk);
            check({tag, ".hold_ov"},  64'(bus.out_valid), 64'(1));
            check({tag, ".hold_q"},   64'(bus.q), 64'(eq));
            check({tag, ".hold_r"},   64'(bus.r), 64'(er));
            check({tag, ".hold_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
            check({tag, ".hold_ovf"}, 64'(bus.overflow), 64'(eovf));
            check({tag, ".hold_rdy"}, 64'(bus.in_ready), 64'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check({tag, ".rdy_in_done"}, 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check({tag, ".ov_after"},  64'(bus.out_valid), 64'(0));
        check({tag, ".rdy_after"}, 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        int unsigned a, b, rr;
        longint unsigned nn;
        int cnt;

        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.n         = '0;
        bus.d         = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst.in_ready",  64'(bus.in_ready), 64'(1));
        check("rst.out_valid", 64'(bus.out_valid), 64'(0));
        check("rst.q",         64'(bus.q), 64'(0));
        check("rst.r",         64'(bus.r), 64'(0));
        check("rst.dbz",       64'(bus.div_by_zero), 64'(0));
        check("rst.ovf",       64'(bus.overflow), 64'(0));

        run_op("basic",  30'd100,        15'd7,     0, 15'd14,    15'd2, 1'b0, 1'b0, 16);
        run_op("maxleg", 30'd1073676289, 15'd32767, 0, 15'd32767, 15'd0, 1'b0, 1'b0, 16);
        run_op("ovf",    30'd163840,     15'd5,     0, 15'd0,     15'd0, 1'b0, 1'b1, 1);
        run_op("dbz",    30'd1234,       15'd0,     0, 15'd0,     15'd0, 1'b1, 1'b0, 1);
        run_op("d_one",  30'd12345,      15'd1,     0, 15'd12345, 15'd0, 1'b0, 1'b0, 16);
        run_op("n_zero", 30'd0,          15'd9,     0, 15'd0,     15'd0, 1'b0, 1'b0, 16);
        run_op("hold",   30'd100,        15'd7,     3, 15'd14,    15'd2, 1'b0, 1'b0, 16);
        run_op("ovf_hi", 30'd1073741823, 15'd32767, 1, 15'd0,     15'd0, 1'b0, 1'b1, 1);

        // Reset in the 5th CALC cycle abandons the operation.
        bus.in_valid = 1'b1;
        bus.n        = 30'd100;
        bus.d        = 15'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst.in_ready",  64'(bus.in_ready), 64'(1));
        check("mid_rst.out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst.q",         64'(bus.q), 64'(0));
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("mid_rst.no_result", 64'(cnt), 64'(0));
        run_op("post_rst", 30'd50, 15'd3, 0, 15'd16, 15'd2, 1'b0, 1'b0, 16);

        for (int i = 0; i < 1000; i++) begin
            a  = $urandom_range(32767, 0);
            b  = $urandom_range(32767, 1);
            rr = $urandom_range(b - 1, 0);
            nn = karatsuba_mul(longint'(a), longint'(b)) + longint'(rr);
            run_op("rt", 30'(nn), 15'(b), 0, 15'(a), 15'(rr), 1'b0, 1'b0, 16);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
